// File: rtl/branch_lut_loader.sv
// Writable 16-entry branch-target table with a write loader, a sequenced bulk clear and a commit state.
// The fetch stage reads target/hit combinationally from the stored entries.
module branch_lut_loader #(
   parameter int unsigned D = 10,
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [3:0]   wr_addr,
   input  logic [D-1:0] wr_data,
   input  logic         commit,
   input  logic         clr_start,
   input  logic [3:0]   addr,
   output logic [D-1:0] target,
   output logic         hit,
   output logic         ready,
   output logic         busy,
   output logic [4:0]   n_valid,
   output logic         err
);

   localparam int unsigned AW = 4;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [D-1:0]    entry_q [N];
   logic [D-1:0]    entry_d [N];
   logic [N-1:0]    valid_q, valid_d;
   logic [CW-1:0]   n_valid_q, n_valid_d;
   logic            err_q, err_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_LOAD;
         cnt_q     <= '0;
         valid_q   <= '0;
         n_valid_q <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < int'(N); i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         n_valid_q <= n_valid_d;
         err_q     <= err_d;
         entry_q   <= entry_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      entry_d   = entry_q;
      valid_d   = valid_q;
      n_valid_d = n_valid_q;
      err_d     = err_q;

      unique case (state_q)
         ST_LOAD: begin
            // A same-cycle write still lands; a following clear erases it.
            if (wr_valid) begin
               entry_d[wr_addr] = wr_data;
               valid_d[wr_addr] = 1'b1;
               if (!valid_q[wr_addr]) begin
                  n_valid_d = n_valid_q + CW'(1);
               end
            end
            if (clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               err_d   = 1'b0;
            end else if (commit) begin
               state_d = ST_READY;
            end
         end
         ST_CLEAR: begin
            entry_d[cnt_q] = '0;
            valid_d[cnt_q] = 1'b0;
            if (valid_q[cnt_q]) begin
               n_valid_d = n_valid_q - CW'(1);
            end
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(N - 1)) begin
               state_d = ST_LOAD;
            end
         end
         ST_READY: begin
            if (wr_valid) begin
               err_d = 1'b1;
            end
            if (clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   assign wr_ready = (state_q == ST_LOAD);
   assign ready    = (state_q == ST_READY);
   assign busy     = (state_q == ST_CLEAR);
   assign n_valid  = n_valid_q;
   assign err      = err_q;
   assign target   = entry_q[addr];
   assign hit      = valid_q[addr];

endmodule

// File: tb/tb_branch_lut_loader.sv
// Scoreboard bench for branch_lut_loader: stimulus pushes expected outputs from a table-level model,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_lut_loader;

   localparam int unsigned D = 10;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [3:0]   wr_addr = '0;
   logic [D-1:0] wr_data = '0;
   logic         commit = 1'b0;
   logic         clr_start = 1'b0;
   logic [3:0]   addr = '0;
   logic [D-1:0] target;
   logic         hit;
   logic         ready;
   logic         busy;
   logic [4:0]   n_valid;
   logic         err;

   int checks = 0;
   int errors = 0;

   branch_lut_loader #(.D(D), .N(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .commit   (commit),
      .clr_start(clr_start),
      .addr     (addr),
      .target   (target),
      .hit      (hit),
      .ready    (ready),
      .busy     (busy),
      .n_valid  (n_valid),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tgt;
      int hit;
      int wr_ready;
      int ready;
      int busy;
      int n_valid;
      int err;
   } exp_t;

   exp_t exp_q[$];

   // Table-level reference: mode 0 = loading, 1 = clearing, 2 = committed.
   int m_mem [16];
   bit m_vld [16];
   int m_mode;
   int m_cidx;
   bit m_err;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_mem[i] = 0;
         m_vld[i] = 1'b0;
      end
      m_mode = 0;
      m_cidx = 0;
      m_err  = 1'b0;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < 16; i++) c += int'(m_vld[i]);
      return c;
   endfunction

   function automatic void model_step(bit wv, int wa, int wd, bit cm, bit cs);
      if (m_mode == 0) begin
         if (wv) begin
            m_mem[wa] = wd;
            m_vld[wa] = 1'b1;
         end
         if (cs) begin
            m_mode = 1;
            m_cidx = 0;
            m_err  = 1'b0;
         end else if (cm) begin
            m_mode = 2;
         end
      end else if (m_mode == 1) begin
         m_mem[m_cidx] = 0;
         m_vld[m_cidx] = 1'b0;
         m_cidx++;
         if (m_cidx == 16) begin
            m_mode = 0;
            m_cidx = 0;
         end
      end else begin
         if (wv) m_err = 1'b1;
         if (cs) begin
            m_mode = 1;
            m_cidx = 0;
            m_err  = 1'b0;
         end
      end
   endfunction

   // One clock of stimulus: drive at posedge+1, predict outputs for this cycle, advance model at the edge.
   task automatic cyc(input bit rst, input bit wv, input int wa, input int wd,
                      input bit cm, input bit cs, input int ra);
      exp_t e;
      reset     = rst;
      wr_valid  = wv;
      wr_addr   = 4'(wa);
      wr_data   = D'(wd);
      commit    = cm;
      clr_start = cs;
      addr      = 4'(ra);
      if (rst) model_reset();
      e.tgt      = m_mem[ra];
      e.hit      = int'(m_vld[ra]);
      e.wr_ready = int'(m_mode == 0);
      e.ready    = int'(m_mode == 2);
      e.busy     = int'(m_mode == 1);
      e.n_valid  = model_count();
      e.err      = int'(m_err);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!rst) model_step(wv, wa, wd, cm, cs);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, $urandom_range(15, 0));
   endtask

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("target",   int'(target),   e.tgt);
         chk("hit",      int'(hit),      e.hit);
         chk("wr_ready", int'(wr_ready), e.wr_ready);
         chk("ready",    int'(ready),    e.ready);
         chk("busy",     int'(busy),     e.busy);
         chk("n_valid",  int'(n_valid),  e.n_valid);
         chk("err",      int'(err),      e.err);
      end
   end

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      // Reset values seen across every read index.
      for (int a = 0; a < 16; a++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, a);
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);

      // Three writes then commit.
      cyc(1'b0, 1'b1, 1, 11,  1'b0, 1'b0, 1);
      cyc(1'b0, 1'b1, 2, 80,  1'b0, 1'b0, 1);
      cyc(1'b0, 1'b1, 4, 113, 1'b0, 1'b0, 2);
      cyc(1'b0, 1'b0, 0, 0,   1'b1, 1'b0, 2);
      cyc(1'b0, 1'b0, 0, 0,   1'b0, 1'b0, 2);
      cyc(1'b0, 1'b0, 0, 0,   1'b1, 1'b0, 3);

      // Write attempt while committed sets sticky err and leaves the table alone.
      cyc(1'b0, 1'b1, 5, 53, 1'b0, 1'b0, 5);
      cyc(1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 5);
      cyc(1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 4);

      // Clear from committed, then overwrite the same entry twice.
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1);
      idle(17);
      cyc(1'b0, 1'b1, 2, 80, 1'b0, 1'b0, 2);
      cyc(1'b0, 1'b1, 2, 68, 1'b0, 1'b0, 2);
      cyc(1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 2);

      // Fill all sixteen entries with full-width data, then a full clear with a same-cycle write.
      for (int a = 0; a < 16; a++) cyc(1'b0, 1'b1, a, 1023 - a, 1'b0, 1'b0, a);
      cyc(1'b0, 1'b1, 9, 7, 1'b1, 1'b1, 9);
      for (int i = 0; i < 18; i++) cyc(1'b0, 1'b1, i % 16, 99, 1'b1, 1'b1, i % 16);

      // Reset aborts a clear midway.
      for (int a = 0; a < 16; a++) cyc(1'b0, 1'b1, a, a + 300, 1'b0, 1'b0, a);
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 0);
      idle(7);
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 12);
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 15);
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 12);

      // clr_start beats commit when both arrive in LOAD.
      cyc(1'b0, 1'b1, 3, 21, 1'b1, 1'b1, 3);
      idle(18);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cyc(1'b0,
             bit'($urandom_range(1, 0)),
             $urandom_range(15, 0),
             $urandom_range(1023, 0),
             bit'($urandom_range(99, 0) < 6),
             bit'($urandom_range(99, 0) < 3),
             $urandom_range(15, 0));
      end
      idle(2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
